// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: idle-head constants and predictor side-band field layout.
package fetch_queue_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] NOP_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_NPC = 32'h0000_0004;
    localparam int META_W = 16;
    localparam int META_JAL_OFF = 0;
    localparam int META_HIT_OFF = 1;
    localparam int META_LPRED_OFF = 2;
    localparam int META_GPRED_OFF = 3;
    localparam int META_GHIST_OFF = 4;
    localparam int META_GHIST_W = 9;
    localparam int META_TPRED_OFF = 13;
    localparam int META_TVALID_OFF = 14;
    localparam int META_COMMIT_OFF = 15;
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: unreset register file, one write port, one asynchronous read port.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 112
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry fetch-to-decode buffer with valid/ready handshakes and one-cycle flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH = 32,
    parameter int META_WIDTH = 16,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [INSTR_WIDTH-1:0]     F_instr_i,
    input  logic [PC_WIDTH-1:0]        F_PC_i,
    input  logic [PC_WIDTH-1:0]        F_nPC_i,
    input  logic [META_WIDTH-1:0]      F_meta_i,
    input  logic                       decode_allow_in_i,
    output logic                       decode_valid_o,
    output logic [INSTR_WIDTH-1:0]     FD_instr_o,
    output logic [PC_WIDTH-1:0]        FD_PC_o,
    output logic [PC_WIDTH-1:0]        FD_nPC_o,
    output logic [META_WIDTH-1:0]      FD_meta_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       afull_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = INSTR_WIDTH + 2 * PC_WIDTH + META_WIDTH;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic push, pop;
    logic [DW-1:0] rd_data;
    logic [INSTR_WIDTH-1:0] rd_instr;
    logic [PC_WIDTH-1:0] rd_pc, rd_npc;
    logic [META_WIDTH-1:0] rd_meta;
    assign fetch_ready_o = count != CW'(DEPTH);
    assign decode_valid_o = count != '0;
    assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop = decode_valid_o & decode_allow_in_i & ~flush_i;
    assign count_o = count;
    assign afull_o = count >= CW'(AFULL_LEVEL);
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    fetch_queue_ram #(.DEPTH(DEPTH), .WIDTH(DW)) u_ram (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({F_instr_i, F_PC_i, F_nPC_i, F_meta_i}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );
    assign {rd_instr, rd_pc, rd_npc, rd_meta} = rd_data;
    // empty head shows a NOP so decode never sees stale storage
    assign FD_instr_o = decode_valid_o ? rd_instr : INSTR_WIDTH'(NOP_INSTR);
    assign FD_PC_o = decode_valid_o ? rd_pc : PC_WIDTH'(NOP_PC);
    assign FD_nPC_o = decode_valid_o ? rd_npc : PC_WIDTH'(NOP_NPC);
    assign FD_meta_o = decode_valid_o ? rd_meta : '0;
    a_valid_hold: assert property (@(posedge clk_i) disable iff (rst)
        (fetch_valid_i && !fetch_ready_o && !flush_i) |=> (fetch_valid_i || flush_i));
    a_count_max: assert property (@(posedge clk_i) disable iff (rst) count <= CW'(DEPTH));
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised, multi-entry successor of the single-stage fetch/decode register.
- Sits between fetch and decode.
- Buffers up to DEPTH fetched instructions, each with its PC, predicted next PC and predictor side-band.
- Uses a valid/ready handshake on both sides, so fetch can run ahead of a stalled decode.
- A flush empties the queue in one cycle on redirect.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- INSTR_WIDTH, 32: instruction width.
- PC_WIDTH, 32: PC / next-PC width.
- META_WIDTH, 16: packed side-band (commit, train valid/predict, global history, global/local predict, hit, jal).
- AFULL_LEVEL, DEPTH-1: occupancy at or above which afull_o asserts.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- flush_i  in  1  synchronous flush (branch redirect / exception)
- fetch_valid_i  in  1  fetch presents a valid entry
- fetch_ready_o  out  1  queue can accept an entry
- F_instr_i  in  INSTR_WIDTH  instruction
- F_PC_i  in  PC_WIDTH  PC of the instruction
- F_nPC_i  in  PC_WIDTH  predicted next PC
- F_meta_i  in  META_WIDTH  predictor/commit side-band
- decode_allow_in_i  in  1  decode accepts the head entry this cycle
- decode_valid_o  out  1  head entry valid
- FD_instr_o  out  INSTR_WIDTH  head instruction
- FD_PC_o  out  PC_WIDTH  head PC
- FD_nPC_o  out  PC_WIDTH  head predicted next PC
- FD_meta_o  out  META_WIDTH  head side-band
- count_o  out  $clog2(DEPTH+1)  current occupancy
- afull_o  out  1  count_o >= AFULL_LEVEL

Behaviour:
- State:
  - Storage array of DEPTH entries.
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Reset (async, rst=1):
  - rd_ptr, wr_ptr and count go to 0 immediately.
  - Storage is not reset.
  - Outputs during and after reset: decode_valid_o=0, fetch_ready_o=1, count_o=0, afull_o=0 (afull_o=1 only if AFULL_LEVEL=0).
  - While empty, FD_instr_o=NOP_INSTR (32'h00000013), FD_PC_o=NOP_PC, FD_nPC_o=NOP_NPC, FD_meta_o=0.
- Handshake:
  - push = fetch_valid_i & fetch_ready_o & ~flush_i.
  - pop = decode_valid_o & decode_allow_in_i & ~flush_i.
- Ready and valid:
  - fetch_ready_o = (count != DEPTH). Derived from registered state only; no combinational path from decode_allow_in_i.
  - decode_valid_o = (count != 0).
- Head outputs:
  - Taken combinationally from storage[rd_ptr] when count != 0; NOP constants otherwise.
- Latency:
  - An entry pushed at edge N is visible at the head after edge N; minimum one-cycle fetch-to-decode latency.
  - There is no bypass when empty.
- Update at each edge:
  - push: storage[wr_ptr] <= inputs; wr_ptr <= wr_ptr+1.
  - pop: rd_ptr <= rd_ptr+1.
  - count <= count + push - pop.
- Simultaneous push and pop:
  - Allowed at any non-full, non-empty occupancy; count is unchanged.
  - When empty, pop is impossible: push only.
  - When full, push is blocked by ready: pop only. A full queue cannot accept an entry in the same cycle decode drains one.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special casing.
- Flush:
  - flush_i=1 at edge N: rd_ptr <= 0, wr_ptr <= 0, count <= 0.
  - Any push or pop in that cycle is discarded.
  - After edge N: decode_valid_o=0 and fetch_ready_o=1.
  - Flush has priority over all other activity.
- Reset mid-operation: all entries are lost; same as the reset values above.
- Protocol assertions:
  - fetch_valid_i must not drop while fetch_ready_o=0 except on flush.
  - count never exceeds DEPTH.

Decomposition:
- Shared package/defines (extend define.v):
  - NOP_INSTR, NOP_PC, NOP_NPC.
  - META field offsets and widths, so fetch and decode pack and unpack F_meta_i / FD_meta_o identically.
- Sub-module: fetch_queue_ram, a DEPTH x (INSTR+2*PC+META) register file with one write port, one asynchronous read port and no reset.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan (DEPTH=4, AFULL_LEVEL=3):
- Reset, then idle → decode_valid_o=0, fetch_ready_o=1, count_o=0, FD_instr_o=32'h00000013.
- Push PC=0x100 with decode_allow_in_i=0 → one cycle later decode_valid_o=1, FD_PC_o=0x100, count_o=1.
- Fill with four pushes (0x100..0x10C) under stall → count_o=4, afull_o=1 from count 3, fetch_ready_o=0. A fifth fetch_valid_i is ignored.
- Full, then raise decode_allow_in_i with fetch_valid_i held → pop 0x100; next cycle count_o=3, fetch_ready_o=1; pending 0x110 enters on the following edge; order preserved.
- Continuous push+pop for 10 cycles → count_o constant, pointers wrap past 3→0, output PCs strictly in push order.
- Flush with count=3 and a simultaneous push → next cycle count_o=0, decode_valid_o=0, pushed entry absent. Separately, assert rst asynchronously mid-burst → outputs revert immediately without a clock edge.
